// File: rtl/hydration_reminder_if.sv
// Signal bundle between the drink counter / user inputs and the hydration reminder.
interface hydration_reminder_if #(
   parameter int unsigned DRINK_W = 6,
   parameter int unsigned TIMER_W = 12
);
   logic               tick;
   logic [DRINK_W-1:0] water_drunk;
   logic               ack;
   logic               remind;
   logic               buzzer;
   logic               goal_met;
   logic [2:0]         state;
   logic [TIMER_W-1:0] elapsed;

   modport master (
      output tick, water_drunk, ack,
      input  remind, buzzer, goal_met, state, elapsed
   );

   modport slave (
      input  tick, water_drunk, ack,
      output remind, buzzer, goal_met, state, elapsed
   );
endinterface

// File: rtl/hydration_reminder.sv
// Drink-interval reminder with escalation to buzzer, snooze and daily-goal tracking.
// Optional HYDRATION_BUZZER_CHIRP_EN: buzzer toggles on each tick while in ALARM.
module hydration_reminder #(
   parameter int unsigned DRINK_W  = 6,
   parameter int unsigned TIMER_W  = 12,
   parameter int unsigned INTERVAL = 1800,
   parameter int unsigned ESCALATE = 120,
   parameter int unsigned SNOOZE   = 300,
   parameter int unsigned GOAL     = 32
) (
   input logic clk,
   input logic reset,
   hydration_reminder_if.slave bus
);
   typedef enum logic [2:0] {
      S_WAIT   = 3'd0,
      S_REMIND = 3'd1,
      S_ALARM  = 3'd2,
      S_SNOOZE = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   localparam logic [TIMER_W-1:0] INTERVAL_T = TIMER_W'(INTERVAL);
   localparam logic [TIMER_W-1:0] ESCALATE_T = TIMER_W'(ESCALATE);
   localparam logic [TIMER_W-1:0] SNOOZE_T   = TIMER_W'(SNOOZE);
   localparam logic [DRINK_W-1:0] GOAL_T     = DRINK_W'(GOAL);

   state_t             st;
   logic [TIMER_W-1:0] elapsed;
   logic [DRINK_W-1:0] prev_drunk;
   logic               remind;
   logic               buzzer;
   logic               goal_met;

   logic               drink;
   logic               at_goal;
   logic [TIMER_W-1:0] inc;

   assign drink   = bus.water_drunk > prev_drunk;
   assign at_goal = bus.water_drunk >= GOAL_T;
   assign inc     = elapsed + 1'b1;

   always_ff @(posedge clk) begin
      if (!reset) begin
         st         <= S_WAIT;
         elapsed    <= '0;
         remind     <= 1'b0;
         buzzer     <= 1'b0;
         goal_met   <= 1'b0;
         prev_drunk <= bus.water_drunk;
      end else begin
         prev_drunk <= bus.water_drunk;
         goal_met   <= at_goal;
         if (st == S_DONE) begin
            elapsed <= '0;
            if (!at_goal) st <= S_WAIT;
         end else if (drink) begin
            // drink outranks ack and swallows a coincident tick
            st      <= at_goal ? S_DONE : S_WAIT;
            elapsed <= '0;
            remind  <= 1'b0;
            buzzer  <= 1'b0;
         end else begin
            case (st)
               S_WAIT: begin
                  if (bus.tick) begin
                     if (inc == INTERVAL_T) begin
                        st      <= S_REMIND;
                        elapsed <= '0;
                        remind  <= 1'b1;
                     end else begin
                        elapsed <= inc;
                     end
                  end
               end
               S_REMIND: begin
                  if (bus.ack) begin
                     st      <= S_SNOOZE;
                     elapsed <= '0;
                     remind  <= 1'b0;
                  end else if (bus.tick) begin
                     if (inc == ESCALATE_T) begin
                        st      <= S_ALARM;
                        elapsed <= '0;
                        buzzer  <= 1'b1;
                     end else begin
                        elapsed <= inc;
                     end
                  end
               end
               S_ALARM: begin
                  if (bus.ack) begin
                     st      <= S_SNOOZE;
                     elapsed <= '0;
                     remind  <= 1'b0;
                     buzzer  <= 1'b0;
                  end else if (bus.tick) begin
                     if (elapsed != '1) elapsed <= inc;
`ifdef HYDRATION_BUZZER_CHIRP_EN
                     buzzer <= ~buzzer;
`endif
                  end
               end
               S_SNOOZE: begin
                  if (bus.tick) begin
                     if (inc == SNOOZE_T) begin
                        st      <= S_REMIND;
                        elapsed <= '0;
                        remind  <= 1'b1;
                     end else begin
                        elapsed <= inc;
                     end
                  end
               end
               default: begin
                  st      <= S_WAIT;
                  elapsed <= '0;
                  remind  <= 1'b0;
                  buzzer  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.state    = st;
   assign bus.elapsed  = elapsed;
   assign bus.remind   = remind;
   assign bus.buzzer   = buzzer;
   assign bus.goal_met = goal_met;
endmodule

// File: tb/tb_hydration_reminder.sv
// Scoreboard bench for hydration_reminder: driver pushes model expectations, monitor pops and compares.
module tb_hydration_reminder;
   localparam int unsigned DW   = 6;
   localparam int unsigned TW   = 12;
   localparam int unsigned P_INT = 10;
   localparam int unsigned P_ESC = 4;
   localparam int unsigned P_SNZ = 3;
   localparam int unsigned P_GOAL = 5;
   localparam int unsigned TMAX = (1 << TW) - 1;

   localparam int M_WAIT = 0, M_REMIND = 1, M_ALARM = 2, M_SNOOZE = 3, M_DONE = 4;

   typedef struct packed {
      logic [2:0]    st;
      logic [TW-1:0] el;
      logic          rem;
      logic          buz;
      logic          gm;
   } obs_t;

   logic clk;
   logic reset;

   hydration_reminder_if #(.DRINK_W(DW), .TIMER_W(TW)) bus ();

   hydration_reminder #(
      .DRINK_W(DW), .TIMER_W(TW), .INTERVAL(P_INT),
      .ESCALATE(P_ESC), .SNOOZE(P_SNZ), .GOAL(P_GOAL)
   ) u_dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   obs_t exp_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   bit   tick_ph = 1'b0;

   // behavioural model
   int m_mode = M_WAIT;
   int m_el   = 0;
   int m_prev = 0;
   int m_gm   = 0;
   int m_aticks = 0;

   function automatic obs_t model_obs();
      obs_t o;
      bit   buz;
      buz = (m_mode == M_ALARM);
`ifdef HYDRATION_BUZZER_CHIRP_EN
      buz = buz && (m_aticks % 2 == 0);
`endif
      o.st  = 3'(m_mode);
      o.el  = TW'(m_el);
      o.rem = (m_mode == M_REMIND) || (m_mode == M_ALARM);
      o.buz = buz;
      o.gm  = (m_gm != 0);
      return o;
   endfunction

   task automatic model_step(input bit r, input int w, input bit a, input bit t);
      bit dr;
      if (!r) begin
         m_mode = M_WAIT; m_el = 0; m_gm = 0; m_prev = w; m_aticks = 0;
         return;
      end
      dr = (w > m_prev);
      m_prev = w;
      m_gm = (w >= P_GOAL);
      if (m_mode == M_DONE) begin
         if (w < P_GOAL) begin m_mode = M_WAIT; m_el = 0; end
      end else if (dr) begin
         m_mode = (w >= P_GOAL) ? M_DONE : M_WAIT;
         m_el = 0;
      end else if (a && (m_mode == M_REMIND || m_mode == M_ALARM)) begin
         m_mode = M_SNOOZE; m_el = 0;
      end else if (t) begin
         case (m_mode)
            M_WAIT:   begin m_el++; if (m_el == P_INT) begin m_mode = M_REMIND; m_el = 0; end end
            M_REMIND: begin m_el++; if (m_el == P_ESC) begin m_mode = M_ALARM; m_el = 0; m_aticks = 0; end end
            M_ALARM:  begin if (m_el < TMAX) m_el++; m_aticks++; end
            M_SNOOZE: begin m_el++; if (m_el == P_SNZ) begin m_mode = M_REMIND; m_el = 0; end end
            default: ;
         endcase
      end
   endtask

   // Applies inputs for the next posedge and records what that edge must produce.
   task automatic cyc(input bit r, input int w, input bit a, input bit t);
      reset = r;
      bus.water_drunk = DW'(w);
      bus.ack = a;
      bus.tick = t;
      model_step(r, w, a, t);
      exp_q.push_back(model_obs());
      @(negedge clk);
   endtask

   task automatic run(input int n, input int w);
      for (int i = 0; i < n; i++) begin
         tick_ph = ~tick_ph;
         cyc(1'b1, w, 1'b0, tick_ph);
      end
   endtask

   task automatic run_until(input int mode, input int el, input bit need_buz, input int w, input string what);
      int k;
      k = 0;
      while (!(m_mode == mode && (el < 0 || m_el == el) &&
               (!need_buz || model_obs().buz) && tick_ph == 1'b0) && k < 20000) begin
         tick_ph = ~tick_ph;
         cyc(1'b1, w, 1'b0, tick_ph);
         k++;
      end
      if (k >= 20000) begin
         n_chk++;
         $display("FAIL %s: model never reached mode %0d (got %0d), required within budget", what, mode, m_mode);
      end
   endtask

   // monitor
   initial begin
      obs_t e, g;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = '{bus.state, bus.elapsed, bus.remind, bus.buzzer, bus.goal_met};
            n_chk++;
            if (g === e) n_pass++;
            else $display("FAIL out@%0t: got st=%0d el=%0d rem=%b buz=%b gm=%b, required st=%0d el=%0d rem=%b buz=%b gm=%b",
                          $time, g.st, g.el, g.rem, g.buz, g.gm, e.st, e.el, e.rem, e.buz, e.gm);
         end
      end
   end

   initial begin
      int w;
      bit a, t, r;
      // reset held with water_drunk=3, then free-running count
      for (int i = 0; i < 3; i++) cyc(1'b0, 3, 1'b0, 1'b0);
      run(6, 3);
      // reminder then escalation, several ALARM ticks
      run_until(M_ALARM, 3, 1'b0, 3, "escalate");
      // ack in ALARM, ack during snooze is ignored, back to REMIND
      cyc(1'b1, 3, 1'b1, 1'b0);
      run(2, 3);
      tick_ph = 1'b0;
      cyc(1'b1, 3, 1'b1, 1'b1);
      run(6, 3);
      run_until(M_REMIND, -1, 1'b0, 3, "resnooze");
      // decrease in REMIND is not a drink; then a drink re-arms
      run(3, 1);
      run(2, 2);
      run_until(M_WAIT, 7, 1'b0, 2, "el7");
      tick_ph = 1'b1;
      cyc(1'b1, 3, 1'b0, 1'b1);
      run(4, 3);
      // goal reached, then rollover
      run(2, 4);
      run(6, 5);
      run(6, 0);
      // reset with ack while buzzer is on
      run_until(M_ALARM, -1, 1'b1, 0, "buz_on");
      cyc(1'b0, 0, 1'b1, 1'b1);
      run(4, 0);
      // elapsed saturation in a long ALARM
      run_until(M_ALARM, -1, 1'b0, 0, "alarm2");
      run(2 * (TMAX + 10), 0);
      cyc(1'b1, 0, 1'b1, 1'b0);
      // randomized traffic
      w = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) == 0) w = $urandom_range(0, 7);
         a = ($urandom_range(0, 9) == 0);
         t = $urandom_range(0, 1);
         r = ($urandom_range(0, 199) != 0);
         cyc(r, w, a, t);
      end
      @(posedge clk);
      #2;
      n_chk++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
